// File: rtl/os_pkg.sv
// rtl/os_pkg.sv - shared types, default geometry and helpers for the overlap-save framer
// Contents: framer state enum, default parameter values, clog2/pointer-width and frame-length helpers,
// default-width packed complex sample {I,Q}.
package os_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } os_state_t;

  localparam int WN_DEF     = 9;
  localparam int N_DEF      = 16;
  localparam int OVL_DEF    = 16;
  localparam int FCNT_W_DEF = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Never return a zero-width pointer, even for a one-entry range.
  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  function automatic int frame_len(input int n, input int ovl);
    return n + ovl;
  endfunction

  typedef struct packed {
    logic signed [WN_DEF-1:0] i;
    logic signed [WN_DEF-1:0] q;
  } os_cplx_t;

endpackage

// File: rtl/os_sample_ram.sv
// rtl/os_sample_ram.sv - simple dual-port sample RAM, synchronous write, registered read with enable
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data.
// Contents are not reset; the framer tracks which entries hold live history.
module os_sample_ram #(
  parameter int DW    = 18,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/os_framer.sv
// rtl/os_framer.sv - overlap-save input framer: N new samples per frame, L = N + OVL samples out
// Ports: i_clk, i_rst_n (async active-low); input stream i_valid/i_xI/i_xQ with o_in_ready;
// output stream o_valid/o_start/o_last/o_xI/o_xQ with i_ready; o_frame_cnt frames emitted.
// Build option OS_FLUSH_EN adds i_flush, a synchronous flush of history and any frame in progress.
module os_framer
  import os_pkg::*;
#(
  parameter int WN     = WN_DEF,
  parameter int N      = N_DEF,
  parameter int OVL    = OVL_DEF,
  parameter int FCNT_W = FCNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [WN-1:0]     i_xI,
  input  logic [WN-1:0]     i_xQ,
  output logic              o_in_ready,
  input  logic              i_ready,
  output logic              o_valid,
  output logic              o_start,
  output logic              o_last,
  output logic [WN-1:0]     o_xI,
  output logic [WN-1:0]     o_xQ,
  output logic [FCNT_W-1:0] o_frame_cnt
`ifdef OS_FLUSH_EN
  ,
  input  logic              i_flush
`endif
);

  localparam int L  = frame_len(N, OVL);
  localparam int AW = ptr_w(L);
  localparam int CW = ptr_w(N);

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(L - 1)) ? '0 : p + 1'b1;
  endfunction

  os_state_t       state, state_nxt;
  logic [AW-1:0]   wp, rp, idx;
  logic [CW-1:0]   new_cnt;
  logic [L-1:0]    written;   // entry holds a sample accepted since the last reset/flush
  logic            rd_live;   // registered read data comes from a written entry
  logic            flush;
  logic            accept, coll_done, hs, last_hs;
  logic            we, re;
  logic [AW-1:0]   wp_inc, raddr;
  logic [2*WN-1:0] rdata;

`ifdef OS_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  assign accept    = i_valid & o_in_ready;
  assign coll_done = accept & (new_cnt == CW'(N - 1));
  assign hs        = o_valid & i_ready;
  assign last_hs   = hs & o_last;
  assign wp_inc    = wrap_inc(wp);

  // Flush wins over a simultaneous accept or handshake.
  assign we    = accept & ~flush;
  // Prefetch the oldest entry together with the N-th write so it is on the
  // outputs one cycle later; it can never be the entry being written.
  assign re    = ~flush & (coll_done | (hs & ~o_last));
  assign raddr = coll_done ? wp_inc : wrap_inc(rp);

  os_sample_ram #(
    .DW    (2 * WN),
    .DEPTH (L),
    .AW    (AW)
  ) u_ram (
    .clk   (i_clk),
    .we    (we),
    .waddr (wp),
    .wdata ({i_xI, i_xQ}),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= COLLECT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (coll_done) state_nxt = EMIT;
        EMIT:    if (last_hs)   state_nxt = COLLECT;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_comb begin
    o_in_ready = 1'b0;
    o_valid    = 1'b0;
    o_start    = 1'b0;
    o_last     = 1'b0;
    case (state)
      COLLECT: o_in_ready = 1'b1;
      EMIT: begin
        o_valid = 1'b1;
        o_start = (idx == '0);
        o_last  = (idx == AW'(L - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wp          <= '0;
      rp          <= '0;
      idx         <= '0;
      new_cnt     <= '0;
      written     <= '0;
      rd_live     <= 1'b0;
      o_frame_cnt <= '0;
    end else if (flush) begin
      wp      <= '0;
      idx     <= '0;
      new_cnt <= '0;
      written <= '0;
      rd_live <= 1'b0;
    end else begin
      if (we) begin
        wp          <= wp_inc;
        written[wp] <= 1'b1;
        new_cnt     <= coll_done ? '0 : new_cnt + 1'b1;
      end
      if (re) rd_live <= written[raddr];
      if (coll_done) begin
        rp  <= wp_inc;
        idx <= '0;
      end else if (hs) begin
        rp  <= wrap_inc(rp);
        idx <= o_last ? '0 : idx + 1'b1;
        if (o_last) o_frame_cnt <= o_frame_cnt + 1'b1;
      end
    end
  end

  // Entries never written since reset/flush read as zero history.
  assign o_xI = rd_live ? rdata[2*WN-1:WN] : '0;
  assign o_xQ = rd_live ? rdata[WN-1:0]    : '0;

endmodule
